// File: rtl/sha_job_scheduler.sv
// Round-robin scheduler sharing one SHA core among NUM_REQ job requesters.
// Latches the winner's message, pulses shaBegin, and returns hash or timeout error.
module sha_job_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MSG_W       = 1976,
    parameter int unsigned HASH_W      = 256,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic [NUM_REQ-1:0]            reqValid,
    input  logic [NUM_REQ*MSG_W-1:0]      reqMsg,
    input  logic                          abort,
    output logic [NUM_REQ-1:0]            reqAck,
    output logic [NUM_REQ-1:0]            respValid,
    output logic [HASH_W-1:0]             respHash,
    output logic                          respError,
    output logic [MSG_W-1:0]              shaMsg,
    output logic                          shaBegin,
    input  logic                          shaComplete,
    input  logic [HASH_W-1:0]             shaOutput,
    output logic [$clog2(NUM_REQ)-1:0]    grantId,
    output logic                          busy
);

    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY
    } state_t;

    state_t          state, state_next;
    logic [TW-1:0]   timer;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   winner;
    logic [GW-1:0]   cand;
    logic            found;
    logic            any_req;
    logic            timeout;

    // Search starts just after the last grant, so last_grant itself is tried last.
    always_comb begin
        winner = last_grant;
        cand   = last_grant;
        found  = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = GW'((32'(last_grant) + i) % NUM_REQ);
            if (!found && reqValid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign any_req  = |reqValid;
    assign timeout  = (timer == TW'(TIMEOUT_CYC - 1));
    assign shaBegin = (state == START);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (any_req) state_next = START;
                START:   state_next = BUSY;
                BUSY:    if (shaComplete || timeout) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timer      <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            grantId    <= '0;
            shaMsg     <= '0;
            reqAck     <= '0;
            respValid  <= '0;
            respHash   <= '0;
            respError  <= 1'b0;
        end else begin
            reqAck    <= '0;
            respValid <= '0;
            if (abort) begin
                timer <= '0;
                if (state != IDLE) last_grant <= grantId;
            end else begin
                case (state)
                    IDLE: begin
                        if (any_req) begin
                            shaMsg         <= reqMsg[winner*MSG_W +: MSG_W];
                            grantId        <= winner;
                            reqAck[winner] <= 1'b1;
                        end
                    end
                    START: timer <= '0;
                    BUSY: begin
                        timer <= timer + 1'b1;
                        // Completion outranks a timeout landing on the same cycle.
                        if (shaComplete) begin
                            respHash           <= shaOutput;
                            respError          <= 1'b0;
                            respValid[grantId] <= 1'b1;
                            last_grant         <= grantId;
                        end else if (timeout) begin
                            respHash           <= '0;
                            respError          <= 1'b1;
                            respValid[grantId] <= 1'b1;
                            last_grant         <= grantId;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sha_job_scheduler.sv
// Directed bench for sha_job_scheduler: single job, fairness, timeout, collision, abort, reset.
module tb_sha_job_scheduler;

    localparam int unsigned NREQ = 4;
    localparam int unsigned MW   = 1976;
    localparam int unsigned HW   = 256;
    localparam int unsigned TO   = 16;

    localparam logic [HW-1:0] H1 = {8'hAB, {30{8'h5A}}, 8'hCD};
    localparam logic [HW-1:0] H2 = {8'h12, {30{8'hC3}}, 8'h34};

    logic                 clk = 1'b0;
    logic                 n_rst;
    logic [NREQ-1:0]      reqValid;
    logic [NREQ*MW-1:0]   reqMsg;
    logic                 abort;
    logic [NREQ-1:0]      reqAck;
    logic [NREQ-1:0]      respValid;
    logic [HW-1:0]        respHash;
    logic                 respError;
    logic [MW-1:0]        shaMsg;
    logic                 shaBegin;
    logic                 shaComplete;
    logic [HW-1:0]        shaOutput;
    logic [1:0]           grantId;
    logic                 busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sha_job_scheduler #(
        .NUM_REQ(NREQ), .MSG_W(MW), .HASH_W(HW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .n_rst(n_rst), .reqValid(reqValid), .reqMsg(reqMsg),
        .abort(abort), .reqAck(reqAck), .respValid(respValid),
        .respHash(respHash), .respError(respError), .shaMsg(shaMsg),
        .shaBegin(shaBegin), .shaComplete(shaComplete), .shaOutput(shaOutput),
        .grantId(grantId), .busy(busy)
    );

    task automatic check(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [MW-1:0] msg_of(input int unsigned i);
        logic [MW-1:0] m;
        m = '0;
        m[31:0]      = 32'hC0DE_0000 + i;
        m[MW-1 -: 32] = 32'hFACE_0000 + i;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack"},   HW'(reqAck),      '0);
        check({tag, "_rv"},    HW'(respValid),   '0);
        check({tag, "_hash"},  respHash,         '0);
        check({tag, "_err"},   HW'(respError),   '0);
        check({tag, "_begin"}, HW'(shaBegin),    '0);
        check({tag, "_busy"},  HW'(busy),        '0);
        check({tag, "_gid"},   HW'(grantId),     '0);
        check({tag, "_msglo"}, HW'(shaMsg[31:0]), '0);
    endtask

    // Presents rv, advances one edge, and checks the ack/START cycle.
    task automatic grant(input logic [NREQ-1:0] rv, input int unsigned id, input string tag);
        logic [NREQ-1:0] oh;
        logic [MW-1:0]   m;
        oh = '0;
        oh[id] = 1'b1;
        m = msg_of(id);
        reqValid = rv;
        tick();
        check({tag, "_ack"},   HW'(reqAck),             HW'(oh));
        check({tag, "_begin"}, HW'(shaBegin),           HW'(1'b1));
        check({tag, "_gid"},   HW'(grantId),            HW'(id));
        check({tag, "_msglo"}, HW'(shaMsg[31:0]),       HW'(m[31:0]));
        check({tag, "_msghi"}, HW'(shaMsg[MW-1 -: 32]), HW'(m[MW-1 -: 32]));
        check({tag, "_rv0"},   HW'(respValid),          '0);
    endtask

    // Lets BUSY run n cycles (timer reaches n-1), then completes with hash h.
    task automatic respond(input int unsigned n, input logic [HW-1:0] h, input int unsigned id,
                           input string tag);
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        repeat (n) tick();
        check({tag, "_pre"}, HW'(respValid), '0);
        shaComplete = 1'b1;
        shaOutput   = h;
        tick();
        shaComplete = 1'b0;
        check({tag, "_rv"},   HW'(respValid), HW'(oh));
        check({tag, "_hash"}, respHash,       h);
        check({tag, "_err"},  HW'(respError), '0);
        check({tag, "_busy"}, HW'(busy),      '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        tick();
    endtask

    initial begin
        n_rst       = 1'b0;
        reqValid    = '0;
        abort       = 1'b0;
        shaComplete = 1'b0;
        shaOutput   = '0;
        for (int i = 0; i < NREQ; i++) reqMsg[i*MW +: MW] = msg_of(i);
        #12;
        check_idle_outputs("rst");
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        tick();

        // Single job from requester 2
        grant(4'b0100, 2, "single");
        reqValid = '0;
        respond(12, H1, 2, "single");
        tick();
        check("single_rv_clr",  HW'(respValid), '0);
        check("single_hold",    respHash,       H1);

        // Fairness with all requesting, then a sparse set
        do_reset();
        grant(4'b1111, 0, "fair0"); respond(10, H1 ^ 256'd0, 0, "fair0");
        grant(4'b1111, 1, "fair1"); respond(10, H1 ^ 256'd1, 1, "fair1");
        grant(4'b1111, 2, "fair2"); respond(10, H1 ^ 256'd2, 2, "fair2");
        grant(4'b1111, 3, "fair3"); respond(10, H1 ^ 256'd3, 3, "fair3");
        grant(4'b1111, 0, "fair4"); respond(10, H1 ^ 256'd4, 0, "fair4");
        grant(4'b1010, 1, "fair5"); respond(10, H1 ^ 256'd5, 1, "fair5");
        grant(4'b1010, 3, "fair6"); reqValid = '0;
        respond(10, H1 ^ 256'd6, 3, "fair6");

        // Timeout: no completion ever
        grant(4'b0001, 0, "to");
        reqValid = '0;
        repeat (TO) tick();
        check("to_pre",  HW'(respValid), '0);
        check("to_busy", HW'(busy),      HW'(1'b1));
        tick();
        check("to_rv",   HW'(respValid), HW'(4'b0001));
        check("to_err",  HW'(respError), HW'(1'b1));
        check("to_hash", respHash,       '0);
        check("to_idle", HW'(busy),      '0);

        // Completion on the final timer cycle beats timeout
        grant(4'b0010, 1, "coll");
        reqValid = '0;
        respond(TO, H2, 1, "coll");

        // Abort in BUSY cycle 5, then a stray completion
        grant(4'b0100, 2, "abt");
        reqValid = '0;
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abt_busy",  HW'(busy),      '0);
        check("abt_rv",    HW'(respValid), '0);
        check("abt_begin", HW'(shaBegin),  '0);
        shaComplete = 1'b1;
        shaOutput   = H1;
        tick();
        shaComplete = 1'b0;
        check("stray_rv",   HW'(respValid), '0);
        check("stray_hash", respHash,       H2);
        check("stray_busy", HW'(busy),      '0);

        // Abort in IDLE blocks arbitration for that cycle
        reqValid = 4'b1011;
        abort    = 1'b1;
        tick();
        abort    = 1'b0;
        check("abti_ack",  HW'(reqAck), '0);
        check("abti_busy", HW'(busy),   '0);
        grant(4'b1011, 3, "after_abt");
        reqValid = '0;

        // Asynchronous reset mid-BUSY
        repeat (3) tick();
        #2;
        n_rst = 1'b0;
        #1;
        check_idle_outputs("midrst");
        check("midrst_msghi", HW'(shaMsg[MW-1 -: 32]), '0);
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        grant(4'b1001, 0, "postrst");
        reqValid = '0;
        respond(4, H1, 0, "postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
